// File: rtl/vga_pkg.sv
// Shared timing defaults, derived raster constants and the pixel type
// for the VGA stream output block.
package vga_pkg;

    // 640x480@60 timing at a 25 MHz pixel rate from a 50 MHz system clock
    localparam int unsigned PIX_DIV_DEF  = 2;
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FRONT_DEF  = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BACK_DEF   = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FRONT_DEF  = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BACK_DEF   = 33;
    localparam int unsigned FIFO_DEPTH_DEF = 16;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned H_CNT_W_DEF = cnt_w(H_TOTAL_DEF);
    localparam int unsigned V_CNT_W_DEF = cnt_w(V_TOTAL_DEF);

    // {R[3:0], G[3:0], B[3:0]}
    typedef logic [11:0] vga_pixel_t;

endpackage

// File: rtl/vga_stream_out_if.sv
// Pixel push stream between the demo system and the VGA output FIFO.
interface vga_stream_out_if;
    import vga_pkg::*;

    logic       pix_valid_i;
    vga_pixel_t pix_data_i;
    logic       pix_ready_o;

    modport master (
        output pix_valid_i,
        output pix_data_i,
        input  pix_ready_o
    );

    modport slave (
        input  pix_valid_i,
        input  pix_data_i,
        output pix_ready_o
    );

endinterface

// File: rtl/vga_pixel_fifo.sv
// Synchronous show-ahead pixel FIFO. The head entry is always visible on
// rdata_o so a pop edge captures it with no extra latency. Full and empty
// are registered so downstream ready logic stays a single inverter.
module vga_pixel_fifo
    import vga_pkg::*;
#(
    parameter int unsigned Depth = FIFO_DEPTH_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  vga_pixel_t wdata_i,
    input  logic       pop_i,
    output vga_pixel_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(Depth);

    vga_pixel_t  r_mem [Depth];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_full;
    logic        r_empty;

    logic        w_push;
    logic        w_pop;
    logic [AW:0] w_wr_next;
    logic [AW:0] w_rd_next;
    logic [AW:0] w_cnt_next;

    assign w_push     = push_i && !r_full;
    assign w_pop      = pop_i && !r_empty;
    assign w_wr_next  = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    assign w_rd_next  = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign w_cnt_next = w_wr_next - w_rd_next;

    assign rdata_o = r_mem[r_rd_ptr[AW-1:0]];
    assign full_o  = r_full;
    assign empty_o = r_empty;

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
        end
    end

    // Pointer and flag update; flags come from the next-state pointers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_full   <= (w_cnt_next == FULL_CNT);
            r_empty  <= (w_wr_next == w_rd_next);
        end
    end

endmodule

// File: rtl/vga_stream_out.sv
// VGA raster generator and pixel drain. Produces hsync/vsync/rgb from the
// system clock and pops one pixel from the FIFO per active pixel tick.
module vga_stream_out
    import vga_pkg::*;
#(
    parameter int unsigned PixDiv    = PIX_DIV_DEF,
    parameter int unsigned HActive   = H_ACTIVE_DEF,
    parameter int unsigned HFront    = H_FRONT_DEF,
    parameter int unsigned HSync     = H_SYNC_DEF,
    parameter int unsigned HBack     = H_BACK_DEF,
    parameter int unsigned VActive   = V_ACTIVE_DEF,
    parameter int unsigned VFront    = V_FRONT_DEF,
    parameter int unsigned VSync     = V_SYNC_DEF,
    parameter int unsigned VBack     = V_BACK_DEF,
    parameter int unsigned FifoDepth = FIFO_DEPTH_DEF
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic             enable_i,
    vga_stream_out_if.slave  pix_if,
    input  logic             clr_underflow_i,
    output logic             underflow_o,
    output logic             frame_start_o,
    output logic             vblank_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output vga_pixel_t       rgb_o
);

    localparam int unsigned HTotal     = HActive + HFront + HSync + HBack;
    localparam int unsigned VTotal     = VActive + VFront + VSync + VBack;
    localparam int unsigned HW         = cnt_w(HTotal);
    localparam int unsigned VW         = cnt_w(VTotal);
    localparam int unsigned DW         = cnt_w(PixDiv);
    localparam int unsigned HSyncStart = HActive + HFront;
    localparam int unsigned HSyncEnd   = HSyncStart + HSync;
    localparam int unsigned VSyncStart = VActive + VFront;
    localparam int unsigned VSyncEnd   = VSyncStart + VSync;

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_vblank;
    logic       r_frame_start;
    logic       r_underflow;
    vga_pixel_t r_rgb;

    logic       w_tick;
    logic       w_active;
    logic       w_pop;
    logic       w_hsync_n;
    logic       w_vsync_n;
    logic       w_vblank;
    logic       w_origin;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    vga_pixel_t w_fifo_rdata;

    assign w_tick    = enable_i && (r_div == DW'(PixDiv - 1));
    assign w_active  = (r_h < HW'(HActive)) && (r_v < VW'(VActive));
    assign w_pop     = w_tick && w_active;
    assign w_hsync_n = !((r_h >= HW'(HSyncStart)) && (r_h < HW'(HSyncEnd)));
    assign w_vsync_n = !((r_v >= VW'(VSyncStart)) && (r_v < VW'(VSyncEnd)));
    assign w_vblank  = (r_v >= VW'(VActive));
    assign w_origin  = (r_h == '0) && (r_v == '0);

    assign pix_if.pix_ready_o = !w_fifo_full;

    assign hsync_o       = r_hsync;
    assign vsync_o       = r_vsync;
    assign vblank_o      = r_vblank;
    assign frame_start_o = r_frame_start;
    assign underflow_o   = r_underflow;
    assign rgb_o         = r_rgb;

    vga_pixel_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_sys_i),
        .rst_i   (rst_sys_i),
        .push_i  (pix_if.pix_valid_i),
        .wdata_i (pix_if.pix_data_i),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // Pixel divider and raster counters; held at the origin while disabled
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i || !enable_i) begin
            r_div <= '0;
            r_h   <= '0;
            r_v   <= '0;
        end else begin
            r_div <= w_tick ? '0 : (r_div + DW'(1));
            if (w_tick) begin
                if (r_h == HW'(HTotal - 1)) begin
                    r_h <= '0;
                    r_v <= (r_v == VW'(VTotal - 1)) ? '0 : (r_v + VW'(1));
                end else begin
                    r_h <= r_h + HW'(1);
                end
            end
        end
    end

    // Registered video outputs for the position the counters held at the tick
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i || !enable_i) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_vblank      <= 1'b0;
            r_frame_start <= 1'b0;
            r_rgb         <= '0;
        end else begin
            r_frame_start <= w_tick && w_origin;
            if (w_tick) begin
                r_hsync  <= w_hsync_n;
                r_vsync  <= w_vsync_n;
                r_vblank <= w_vblank;
                r_rgb    <= (w_active && !w_fifo_empty) ? w_fifo_rdata : '0;
            end
        end
    end

    // Sticky underflow: an active pixel found no data; clear wins over set
    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_underflow <= 1'b0;
        end else if (clr_underflow_i) begin
            r_underflow <= 1'b0;
        end else if (w_pop && w_fifo_empty) begin
            r_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out. Horizontal timing uses the real
// 640x480 values; the vertical total is shortened to 13 lines so whole
// frames fit in a short run.
module tb_vga_stream_out;
    import vga_pkg::*;

    localparam int unsigned TB_VA = 8;
    localparam int unsigned TB_VF = 2;
    localparam int unsigned TB_VS = 2;
    localparam int unsigned TB_VB = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic       uf;
    logic       fs;
    logic       vb;
    logic       hs;
    logic       vs;
    vga_pixel_t rgb;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    vga_stream_out_if pix_if();

    vga_stream_out #(
        .PixDiv    (2),
        .HActive   (640),
        .HFront    (16),
        .HSync     (96),
        .HBack     (48),
        .VActive   (TB_VA),
        .VFront    (TB_VF),
        .VSync     (TB_VS),
        .VBack     (TB_VB),
        .FifoDepth (16)
    ) dut (
        .clk_sys_i       (clk),
        .rst_sys_i       (rst),
        .enable_i        (en),
        .pix_if          (pix_if),
        .clr_underflow_i (clr),
        .underflow_o     (uf),
        .frame_start_o   (fs),
        .vblank_o        (vb),
        .hsync_o         (hs),
        .vsync_o         (vs),
        .rgb_o           (rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         m;
        logic [11:0] rgb;
        logic       hs;
        logic       vs;
        logic       vb;
        logic       fs;
        logic       uf;
        logic       rdy;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%03h, expected 0x%03h", name, act, exp);
        end
    endtask

    // Advance to the falling edge that follows rising edge number m-1 after enable
    task automatic adv_to(input int m);
        while (cyc < m) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        // m, rgb, hs, vs, vb, fs, uf, rdy ; pixel k shows at m = 2+2k and 3+2k
        tbl[0]  = '{1,     12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2,     12'h001, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{3,     12'h001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4,     12'h002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{12,    12'h006, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{32,    12'h010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{33,    12'h010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{34,    12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1313,  12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1314,  12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1505,  12'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1506,  12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1602,  12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{12801, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{12802, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{16001, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[16] = '{16002, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[17] = '{19201, 12'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[18] = '{19202, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[19] = '{20801, 12'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[20] = '{20802, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[21] = '{20803, 12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        pix_if.pix_valid_i = 1'b0;
        pix_if.pix_data_i  = '0;

        // Reset for three cycles
        repeat (3) @(negedge clk);
        chk("rst.hsync", 12'(hs), 12'h1);
        chk("rst.vsync", 12'(vs), 12'h1);
        chk("rst.rgb", rgb, 12'h000);
        chk("rst.underflow", 12'(uf), 12'h0);
        chk("rst.ready", 12'(pix_if.pix_ready_o), 12'h1);
        chk("rst.frame_start", 12'(fs), 12'h0);
        chk("rst.vblank", 12'(vb), 12'h0);
        rst = 1'b0;

        // Pre-fill 0x001..0x010 with the raster stopped; FIFO ends full
        for (int i = 1; i <= 16; i++) begin
            pix_if.pix_valid_i = 1'b1;
            pix_if.pix_data_i  = 12'(i);
            @(negedge clk);
            if (i == 15) chk("fill.ready_15", 12'(pix_if.pix_ready_o), 12'h1);
        end
        chk("fill.ready_16", 12'(pix_if.pix_ready_o), 12'h0);
        chk("fill.idle_rgb", rgb, 12'h000);
        // A 17th push held against a full FIFO must be refused
        pix_if.pix_data_i = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("full.hold%0d", i), 12'(pix_if.pix_ready_o), 12'h0);
        end
        pix_if.pix_valid_i = 1'b0;
        en  = 1'b1;
        cyc = 0;

        // Pre-fill drain, underflow, then raster timing over a whole frame
        for (int i = 0; i < 22; i++) begin
            adv_to(tbl[i].m);
            chk($sformatf("v%0d.rgb", i), rgb, tbl[i].rgb);
            chk($sformatf("v%0d.hsync", i), 12'(hs), 12'(tbl[i].hs));
            chk($sformatf("v%0d.vsync", i), 12'(vs), 12'(tbl[i].vs));
            chk($sformatf("v%0d.vblank", i), 12'(vb), 12'(tbl[i].vb));
            chk($sformatf("v%0d.frame_start", i), 12'(fs), 12'(tbl[i].fs));
            chk($sformatf("v%0d.underflow", i), 12'(uf), 12'(tbl[i].uf));
            chk($sformatf("v%0d.ready", i), 12'(pix_if.pix_ready_o), 12'(tbl[i].rdy));
        end

        // Clear coinciding with an empty pop wins, next empty pop sets again
        clr = 1'b1;
        adv_to(20804);
        chk("uf.clr_wins", 12'(uf), 12'h0);
        clr = 1'b0;
        adv_to(20805);
        chk("uf.still_clear", 12'(uf), 12'h0);
        adv_to(20806);
        chk("uf.reset_again", 12'(uf), 12'h1);

        // Mid-frame reset at line 5, pixel 300 with one entry queued
        adv_to(29401);
        pix_if.pix_valid_i = 1'b1;
        pix_if.pix_data_i  = 12'h456;
        adv_to(29402);
        chk("mid.rgb_before", rgb, 12'h000);
        chk("mid.vblank_before", 12'(vb), 12'h0);
        chk("mid.ready_before", 12'(pix_if.pix_ready_o), 12'h1);
        pix_if.pix_valid_i = 1'b0;
        rst = 1'b1;
        adv_to(29403);
        chk("mid.hsync", 12'(hs), 12'h1);
        chk("mid.vsync", 12'(vs), 12'h1);
        chk("mid.rgb", rgb, 12'h000);
        chk("mid.underflow", 12'(uf), 12'h0);
        chk("mid.ready", 12'(pix_if.pix_ready_o), 12'h1);
        adv_to(29404);
        rst = 1'b0;
        cyc = 0;
        adv_to(1);
        chk("restart.fs_early", 12'(fs), 12'h0);
        adv_to(2);
        chk("restart.fs", 12'(fs), 12'h1);
        chk("restart.rgb_discarded", rgb, 12'h000);
        chk("restart.underflow", 12'(uf), 12'h1);
        adv_to(3);
        chk("restart.fs_one_cycle", 12'(fs), 12'h0);

        // Dropping enable during hsync low idles outputs on the next edge
        adv_to(1314);
        chk("dis.hsync_low", 12'(hs), 12'h0);
        en = 1'b0;
        adv_to(1315);
        chk("dis.hsync_idle", 12'(hs), 12'h1);
        chk("dis.rgb_idle", rgb, 12'h000);
        chk("dis.fs_idle", 12'(fs), 12'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
